// File: rtl/cv32e40p_ft_replica_manager_if.sv
// Replica-manager bus: per-unit breakage/error flags in, exclusion mask and status out.
// The master drives the flags and the clear request; the manager is the slave.
interface cv32e40p_ft_replica_manager_if #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CNT_W   = 8
);
    logic [N_UNITS*3-1:0] is_broken;
    logic [N_UNITS-1:0]   err_detected;
    logic [N_UNITS-1:0]   err_corrected;
    logic                 clr_req;
    logic [2:0]           set_broken;
    logic [1:0]           state;
    logic                 failsafe;
    logic [CNT_W-1:0]     err_cnt;
    logic                 clr_ack;

    modport master (
        output is_broken, err_detected, err_corrected, clr_req,
        input  set_broken, state, failsafe, err_cnt, clr_ack
    );

    modport slave (
        input  is_broken, err_detected, err_corrected, clr_req,
        output set_broken, state, failsafe, err_cnt, clr_ack
    );
endinterface

// File: rtl/cv32e40p_ft_replica_manager.sv
// Core-level TMR replica manager: picks the excluded replica, sequences
// degrade -> software recovery -> normal, and latches fail-safe.
module cv32e40p_ft_replica_manager #(
    parameter int unsigned N_UNITS       = 4,
    parameter int unsigned RETEST_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input logic                          clk,
    input logic                          rst_n,
    cv32e40p_ft_replica_manager_if.slave bus
);
    localparam int unsigned RtW = (RETEST_CYCLES > 1) ? $clog2(RETEST_CYCLES) : 1;

    typedef enum logic [1:0] {
        StNormal   = 2'b00,
        StDegraded = 2'b01,
        StRecover  = 2'b10,
        StFailsafe = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       excl_q, excl_d;
    logic [2:0]       set_broken_q, set_broken_d;
    logic [RtW-1:0]   rt_q, rt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             clr_ack_q, clr_ack_d;
    logic             ack_done_q, ack_done_d;

    logic [2:0] brk;
    logic [1:0] nbrk;
    logic       uncorr;
    logic       clr_cnt;

    always_comb begin
        brk    = '0;
        uncorr = 1'b0;
        for (int u = 0; u < N_UNITS; u++) begin
            brk    = brk | bus.is_broken[u*3 +: 3];
            uncorr = uncorr | (bus.err_detected[u] & ~bus.err_corrected[u]);
        end
        nbrk = {1'b0, brk[0]} + {1'b0, brk[1]} + {1'b0, brk[2]};
    end

    always_comb begin
        state_d   = state_q;
        excl_d    = excl_q;
        rt_d      = rt_q;
        clr_ack_d = 1'b0;
        clr_cnt   = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (uncorr || nbrk >= 2'd2) begin
                    state_d = StFailsafe;
                end else if (nbrk == 2'd1) begin
                    state_d = StDegraded;
                    excl_d  = brk;
                end else if (bus.clr_req && !ack_done_q) begin
                    clr_ack_d = 1'b1;
                    clr_cnt   = 1'b1;
                end
            end
            StDegraded: begin
                if (uncorr || (brk & ~excl_q) != 3'b000) begin
                    state_d = StFailsafe;
                end else if (bus.clr_req) begin
                    state_d = StRecover;
                    rt_d    = '0;
                end
            end
            StRecover: begin
                if (uncorr || nbrk >= 2'd2) begin
                    state_d = StFailsafe;
                end else if (brk == 3'b000 && bus.err_detected == '0) begin
                    if (rt_q == RtW'(RETEST_CYCLES - 1)) begin
                        state_d   = StNormal;
                        excl_d    = '0;
                        clr_ack_d = 1'b1;
                        clr_cnt   = 1'b1;
                    end else begin
                        rt_d = rt_q + 1'b1;
                    end
                end else begin
                    rt_d = '0;
                end
            end
            StFailsafe: ;
            default: state_d = StFailsafe;
        endcase

        // In fail-safe each distinct request is acknowledged exactly once and otherwise ignored.
        if (state_d == StFailsafe) begin
            clr_ack_d = bus.clr_req & ~ack_done_q;
        end
        ack_done_d = bus.clr_req & (ack_done_q | clr_ack_d);

        set_broken_d = (state_d == StDegraded || state_d == StFailsafe) ? excl_d : 3'b000;

        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (|bus.err_corrected && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StNormal;
            excl_q       <= '0;
            set_broken_q <= '0;
            rt_q         <= '0;
            err_cnt_q    <= '0;
            clr_ack_q    <= 1'b0;
            ack_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            excl_q       <= excl_d;
            set_broken_q <= set_broken_d;
            rt_q         <= rt_d;
            err_cnt_q    <= err_cnt_d;
            clr_ack_q    <= clr_ack_d;
            ack_done_q   <= ack_done_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.set_broken = set_broken_q;
    assign bus.failsafe   = (state_q == StFailsafe);
    assign bus.err_cnt    = err_cnt_q;
    assign bus.clr_ack    = clr_ack_q;
endmodule

// File: tb/tb_cv32e40p_ft_replica_manager.sv
// Directed bench for the replica manager: hand-computed expectations per scenario.
module tb_cv32e40p_ft_replica_manager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cv32e40p_ft_replica_manager_if #(.N_UNITS(4), .CNT_W(8)) bus ();

    cv32e40p_ft_replica_manager #(
        .N_UNITS      (4),
        .RETEST_CYCLES(16),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.is_broken     = '0;
        bus.err_detected  = '0;
        bus.err_corrected = '0;
        bus.clr_req       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_mask", 32'(bus.set_broken), 32'd0);
        check("rst_ack", 32'(bus.clr_ack), 32'd0);
        rst_n = 1'b1;
    endtask

    // From DEGRADED: request recovery and walk 16 clean cycles back to NORMAL.
    task automatic recover_to_normal(input string tag);
        bus.clr_req = 1'b1;
        tick();
        check({tag, "_enter_rec"}, 32'(bus.state), 32'd2);
        check({tag, "_rec_mask"}, 32'(bus.set_broken), 32'd0);
        check({tag, "_rec_noack"}, 32'(bus.clr_ack), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check({tag, "_still_rec"}, 32'(bus.state), 32'd2);
        end
        tick();
        check({tag, "_normal"}, 32'(bus.state), 32'd0);
        check({tag, "_ack"}, 32'(bus.clr_ack), 32'd1);
        bus.clr_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(bus.clr_ack), 32'd0);
    endtask

    initial begin
        idle_inputs();
        #12;
        do_reset();

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_state", 32'(bus.state), 32'd0);
            check("idle_mask", 32'(bus.set_broken), 32'd0);
            check("idle_cnt", 32'(bus.err_cnt), 32'd0);
            check("idle_ack", 32'(bus.clr_ack), 32'd0);
        end

        // 2: is_broken[2][1] one cycle -> DEGRADED with mask 010, then recovery
        bus.is_broken[2*3+1] = 1'b1;
        tick();
        check("deg_state", 32'(bus.state), 32'd1);
        check("deg_mask", 32'(bus.set_broken), 32'b010);
        bus.is_broken = '0;
        tick();
        check("deg_hold", 32'(bus.state), 32'd1);
        recover_to_normal("t2");

        // 3: breakage in RECOVER restarts the retest counter
        bus.is_broken[0*3+1] = 1'b1;
        tick();
        check("t3_deg", 32'(bus.set_broken), 32'b010);
        bus.is_broken = '0;
        bus.clr_req   = 1'b1;
        tick();
        check("t3_rec", 32'(bus.state), 32'd2);
        for (int i = 0; i < 10; i++) tick();
        bus.is_broken[0*3+1] = 1'b1;
        tick();
        check("t3_brk_rec", 32'(bus.state), 32'd2);
        check("t3_brk_mask", 32'(bus.set_broken), 32'd0);
        bus.is_broken = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t3_restart", 32'(bus.state), 32'd2);
        end
        tick();
        check("t3_normal", 32'(bus.state), 32'd0);
        check("t3_ack", 32'(bus.clr_ack), 32'd1);
        bus.clr_req = 1'b0;
        tick();

        // 4: DEGRADED on replica 0, second replica breaks -> FAILSAFE
        bus.is_broken[1*3+0] = 1'b1;
        tick();
        check("t4_deg", 32'(bus.state), 32'd1);
        check("t4_mask", 32'(bus.set_broken), 32'b001);
        bus.is_broken[0*3+2] = 1'b1;
        tick();
        check("t4_fs", 32'(bus.state), 32'd3);
        check("t4_fs_flag", 32'(bus.failsafe), 32'd1);
        check("t4_fs_mask", 32'(bus.set_broken), 32'b001);
        bus.is_broken = '0;
        bus.clr_req   = 1'b1;
        tick();
        check("t4_ack", 32'(bus.clr_ack), 32'd1);
        check("t4_stay", 32'(bus.state), 32'd3);
        tick();
        check("t4_ack_once", 32'(bus.clr_ack), 32'd0);
        check("t4_mask_frozen", 32'(bus.set_broken), 32'b001);
        bus.clr_req = 1'b0;
        tick();
        do_reset();

        // 5: uncorrected error beats single breakage
        bus.err_detected[3] = 1'b1;
        bus.is_broken[2*3+0] = 1'b1;
        tick();
        check("t5_fs", 32'(bus.state), 32'd3);
        check("t5_flag", 32'(bus.failsafe), 32'd1);
        check("t5_mask", 32'(bus.set_broken), 32'b000);
        do_reset();

        // reset mid-RECOVER drops the request without ack
        bus.is_broken[0*3+2] = 1'b1;
        tick();
        bus.is_broken = '0;
        bus.clr_req   = 1'b1;
        tick();
        check("mid_rec", 32'(bus.state), 32'd2);
        do_reset();
        tick();
        check("mid_rec_noack", 32'(bus.clr_ack), 32'd0);

        // 6: saturating corrected-error counter and clear
        bus.err_corrected[0] = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("t6_cnt100", 32'(bus.err_cnt), 32'd100);
        check("t6_state", 32'(bus.state), 32'd0);
        for (int i = 0; i < 200; i++) tick();
        check("t6_sat", 32'(bus.err_cnt), 32'd255);
        bus.clr_req = 1'b1;
        tick();
        check("t6_clr_prio", 32'(bus.err_cnt), 32'd0);
        check("t6_ack", 32'(bus.clr_ack), 32'd1);
        bus.err_corrected = '0;
        tick();
        check("t6_ack_once", 32'(bus.clr_ack), 32'd0);
        bus.clr_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
